// File: rtl/game_timer_ctrl_if.sv
// Signal bundle between the Frogger round sequencer and its surroundings:
// board buttons, game-logic events, timer BCD inputs and the control/status outputs.
interface game_timer_ctrl_if;
    logic       btn_start;
    logic       btn_pause;
    logic       frog_home;
    logic       frog_hit;
    logic       tick_1Hz;
    logic [3:0] sec_1s;
    logic [3:0] sec_10s;
    logic [3:0] min_1s;
    logic [3:0] min_10s;
    logic       timer_pause;
    logic       timer_clear;
    logic [2:0] state;
    logic [1:0] lives;
    logic [2:0] level;
    logic       game_over;
    logic       game_won;

    // The sequencer drives the timer controls and game status
    modport master (
        input  btn_start, btn_pause, frog_home, frog_hit, tick_1Hz,
        input  sec_1s, sec_10s, min_1s, min_10s,
        output timer_pause, timer_clear, state, lives, level, game_over, game_won
    );

    modport slave (
        output btn_start, btn_pause, frog_home, frog_hit, tick_1Hz,
        output sec_1s, sec_10s, min_1s, min_10s,
        input  timer_pause, timer_clear, state, lives, level, game_over, game_won
    );
endinterface

// File: rtl/game_timer_ctrl.sv
// Frogger round sequencer: debounces start/pause, runs the game-flow FSM and
// drives the binary clock timer's pause and clear inputs.

module GameTimerDebounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] count_q, count_d;
    logic          press_q, press_d;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            count_q <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            count_q <= count_d;
            press_q <= press_d;
        end
    end

    // The counter only runs while the synced input disagrees with the debounced level;
    // any agreement restarts it, so a bounce never accumulates toward a change.
    always_comb begin
        level_d = level_q;
        count_d = '0;
        press_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (count_q == CNT_LAST) begin
                level_d = sync_q[1];
                press_d = sync_q[1];
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    assign press_o = press_q;
endmodule

module game_timer_ctrl #(
    parameter int TIME_LIMIT_S = 99,
    parameter int LIVES_INIT   = 3,
    parameter int LEVELS       = 5,
    parameter int HOLD_S       = 2,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    game_timer_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        DIE   = 3'd3,
        WIN   = 3'd4,
        OVER  = 3'd5
    } state_t;

    localparam logic [11:0] LIMIT      = 12'(TIME_LIMIT_S);
    localparam logic [1:0]  LIVES_LOAD = 2'(LIVES_INIT);
    localparam logic [2:0]  LAST_LEVEL = 3'(LEVELS - 1);
    localparam logic [1:0]  HOLD_LAST  = 2'(HOLD_S - 1);

    logic       startPress, pausePress;
    logic [2:0] tickSync_q;
    logic       tickEvent;
    logic [11:0] minutes, elapsed;
    logic       timeout;

    state_t     state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [2:0] level_q, level_d;
    logic [1:0] hold_q, hold_d;
    logic       lastRound_q, lastRound_d;
    logic       gameOver_q, gameOver_d;
    logic       gameWon_q, gameWon_d;
    logic       timerClear_q, timerClear_d;

    GameTimerDebounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) startDebounce (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .btn_i      (bus.btn_start),
        .press_o    (startPress)
    );

    GameTimerDebounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) pauseDebounce (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .btn_i      (bus.btn_pause),
        .press_o    (pausePress)
    );

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            tickSync_q <= '0;
        end else begin
            tickSync_q <= {tickSync_q[1:0], bus.tick_1Hz};
        end
    end

    // The tick event lags the timer's second edge enough that its BCD digits are stable
    assign tickEvent = tickSync_q[1] & ~tickSync_q[2];
    assign minutes   = 12'(bus.min_10s) * 12'd10 + 12'(bus.min_1s);
    assign elapsed   = minutes * 12'd60 + 12'(bus.sec_10s) * 12'd10 + 12'(bus.sec_1s);
    assign timeout   = tickEvent && (elapsed >= LIMIT);

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lives_q      <= LIVES_LOAD;
            level_q      <= '0;
            hold_q       <= '0;
            lastRound_q  <= 1'b0;
            gameOver_q   <= 1'b0;
            gameWon_q    <= 1'b0;
            timerClear_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            hold_q       <= hold_d;
            lastRound_q  <= lastRound_d;
            gameOver_q   <= gameOver_d;
            gameWon_q    <= gameWon_d;
            timerClear_q <= timerClear_d;
        end
    end

    // lastRound is latched on DIE/WIN entry, because the level bump made on entry can
    // itself land on the final level and must not be mistaken for having cleared it.
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        level_d     = level_q;
        hold_d      = hold_q;
        lastRound_d = lastRound_q;
        gameOver_d  = gameOver_q;
        gameWon_d   = gameWon_q;
        case (state_q)
            IDLE: begin
                if (startPress) state_d = RUN;
            end
            RUN: begin
                if (bus.frog_home) begin
                    state_d     = WIN;
                    hold_d      = '0;
                    lastRound_d = (level_q == LAST_LEVEL);
                    if (level_q != LAST_LEVEL) level_d = level_q + 3'd1;
                end else if (bus.frog_hit || timeout) begin
                    state_d     = DIE;
                    hold_d      = '0;
                    lastRound_d = (lives_q <= 2'd1);
                    if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
                end else if (pausePress) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (pausePress) state_d = RUN;
            end
            DIE, WIN: begin
                if (lastRound_q) begin
                    state_d    = OVER;
                    gameOver_d = 1'b1;
                    gameWon_d  = (state_q == WIN);
                end else if (tickEvent) begin
                    if (hold_q == HOLD_LAST) state_d = RUN;
                    else hold_d = hold_q + 2'd1;
                end
            end
            OVER: begin
                if (startPress) begin
                    state_d    = IDLE;
                    lives_d    = LIVES_LOAD;
                    level_d    = '0;
                    gameOver_d = 1'b0;
                    gameWon_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Resuming from PAUSE must keep the elapsed time, so only fresh rounds clear the timer
    always_comb begin
        timerClear_d = (state_d == RUN) &&
                       (state_q == IDLE || state_q == DIE || state_q == WIN);
    end

    assign bus.timer_pause = (state_q != RUN);
    assign bus.timer_clear = timerClear_q;
    assign bus.state       = state_q;
    assign bus.lives       = lives_q;
    assign bus.level       = level_q;
    assign bus.game_over   = gameOver_q;
    assign bus.game_won    = gameWon_q;
endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: directed game scenarios then random events, each checked
// against an event-level model of the game rules.
module tb_game_timer_ctrl;
    localparam int TIME_LIMIT = 5;
    localparam int LIVES      = 3;
    localparam int LEVELS     = 2;
    localparam int HOLD       = 2;
    localparam int DEB        = 4;

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DIE = 3, S_WIN = 4, S_OVER = 5;
    localparam int ACT_START = 0, ACT_PAUSE = 1, ACT_HOME = 2, ACT_HIT = 3, ACT_BOTH = 4, ACT_TICK = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    game_timer_ctrl_if bus();

    game_timer_ctrl #(
        .TIME_LIMIT_S (TIME_LIMIT),
        .LIVES_INIT   (LIVES),
        .LEVELS       (LEVELS),
        .HOLD_S       (HOLD),
        .DEBOUNCE_CYC (DEB)
    ) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int mState, mLives, mLevel, mHold, mOver, mWon, mClears;
    int clearPulses = 0;
    int clearCycles = 0;
    logic prevClear = 1'b0;

    // Counts timer_clear pulses and their total width
    always @(negedge clk) begin
        if (bus.timer_clear === 1'b1) begin
            clearCycles++;
            if (!prevClear) clearPulses++;
        end
        prevClear = (bus.timer_clear === 1'b1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkSnapshot(input string tag);
        checkOutput({tag, ".state"}, 32'(bus.state), mState);
        checkOutput({tag, ".lives"}, 32'(bus.lives), mLives);
        checkOutput({tag, ".level"}, 32'(bus.level), mLevel);
        checkOutput({tag, ".over"}, 32'(bus.game_over), mOver);
        checkOutput({tag, ".won"}, 32'(bus.game_won), mWon);
        checkOutput({tag, ".pause"}, 32'(bus.timer_pause), (mState != S_RUN) ? 1 : 0);
        checkOutput({tag, ".clearPulses"}, clearPulses, mClears);
        checkOutput({tag, ".clearCycles"}, clearCycles, mClears);
    endtask

    task automatic modelReset();
        mState = S_IDLE; mLives = LIVES; mLevel = 0; mHold = 0; mOver = 0; mWon = 0;
    endtask

    task automatic modelEnterRun();
        mState = S_RUN;
        mClears++;
    endtask

    task automatic modelDie();
        mLives = mLives - 1;
        if (mLives == 0) begin
            mState = S_OVER; mOver = 1; mWon = 0;
        end else begin
            mState = S_DIE; mHold = 0;
        end
    endtask

    task automatic modelWin();
        if (mLevel == LEVELS - 1) begin
            mState = S_OVER; mOver = 1; mWon = 1;
        end else begin
            mLevel = mLevel + 1; mState = S_WIN; mHold = 0;
        end
    endtask

    task automatic modelEvent(input int act, input int elapsed);
        case (act)
            ACT_START: begin
                if (mState == S_IDLE) modelEnterRun();
                else if (mState == S_OVER) modelReset();
            end
            ACT_PAUSE: begin
                if (mState == S_RUN) mState = S_PAUSE;
                else if (mState == S_PAUSE) mState = S_RUN;
            end
            ACT_HOME, ACT_BOTH: if (mState == S_RUN) modelWin();
            ACT_HIT: if (mState == S_RUN) modelDie();
            ACT_TICK: begin
                if (mState == S_RUN && elapsed >= TIME_LIMIT) modelDie();
                else if (mState == S_DIE || mState == S_WIN) begin
                    mHold++;
                    if (mHold == HOLD) modelEnterRun();
                end
            end
            default: ;
        endcase
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pressButton(input bit isPause);
        @(negedge clk);
        if (isPause) bus.btn_pause = 1'b1; else bus.btn_start = 1'b1;
        waitCycles(DEB + 6);
        bus.btn_pause = 1'b0;
        bus.btn_start = 1'b0;
        waitCycles(DEB + 6);
    endtask

    task automatic pulseFrog(input logic home, input logic hit);
        @(negedge clk);
        bus.frog_home = home;
        bus.frog_hit  = hit;
        @(negedge clk);
        bus.frog_home = 1'b0;
        bus.frog_hit  = 1'b0;
        waitCycles(3);
    endtask

    task automatic tickOnce(input logic [3:0] m10, input logic [3:0] m1, input logic [3:0] s10, input logic [3:0] s1);
        @(negedge clk);
        bus.min_10s = m10; bus.min_1s = m1; bus.sec_10s = s10; bus.sec_1s = s1;
        bus.tick_1Hz = 1'b1;
        waitCycles(4);
        bus.tick_1Hz = 1'b0;
        waitCycles(4);
    endtask

    // Drives one game event and advances the model by the same event
    task automatic applyStimulus(input int act, input logic [3:0] m10, input logic [3:0] m1,
                                 input logic [3:0] s10, input logic [3:0] s1);
        int elapsed;
        elapsed = ((int'(m10) * 10 + int'(m1)) * 60 + int'(s10) * 10 + int'(s1)) % 4096;
        case (act)
            ACT_START: pressButton(1'b0);
            ACT_PAUSE: pressButton(1'b1);
            ACT_HOME:  pulseFrog(1'b1, 1'b0);
            ACT_HIT:   pulseFrog(1'b0, 1'b1);
            ACT_BOTH:  pulseFrog(1'b1, 1'b1);
            default:   tickOnce(m10, m1, s10, s1);
        endcase
        modelEvent(act, elapsed);
    endtask

    initial begin
        int lat;
        int act;
        logic [3:0] m1, s10, s1;

        bus.btn_start = 0; bus.btn_pause = 0; bus.frog_home = 0; bus.frog_hit = 0;
        bus.tick_1Hz = 0; bus.sec_1s = 0; bus.sec_10s = 0; bus.min_1s = 0; bus.min_10s = 0;
        mClears = 0;
        modelReset();
        waitCycles(3);
        checkSnapshot("reset");
        checkOutput("reset.clear", 32'(bus.timer_clear), 0);
        @(negedge clk) reset = 1'b0;
        waitCycles(2);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk) bus.btn_start = 1'b1;
            waitCycles(3);
            bus.btn_start = 1'b0;
            waitCycles(3);
        end
        waitCycles(10);
        checkSnapshot("bounce");

        @(negedge clk) bus.btn_start = 1'b1;
        lat = 0;
        while (bus.state !== 3'd1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("startLatencyInRange", (lat >= 6 && lat <= 9) ? 1 : 0, 1);
        waitCycles(3);
        bus.btn_start = 1'b0;
        waitCycles(DEB + 6);
        modelEvent(ACT_START, 0);
        checkSnapshot("start");

        applyStimulus(ACT_PAUSE, 0, 0, 0, 0);
        checkSnapshot("pauseOn");
        applyStimulus(ACT_HIT, 0, 0, 0, 0);
        checkSnapshot("pauseHitIgnored");
        applyStimulus(ACT_TICK, 0, 0, 0, 9);
        checkSnapshot("pauseTickIgnored");
        applyStimulus(ACT_PAUSE, 0, 0, 0, 0);
        checkSnapshot("pauseOff");

        applyStimulus(ACT_HOME, 0, 0, 0, 0);
        checkSnapshot("win1");
        applyStimulus(ACT_TICK, 0, 0, 0, 1);
        checkSnapshot("winHold1");
        applyStimulus(ACT_TICK, 0, 0, 0, 2);
        checkSnapshot("winHold2");

        applyStimulus(ACT_TICK, 0, 0, 0, 4);
        checkSnapshot("time0_04");
        applyStimulus(ACT_TICK, 0, 0, 0, 5);
        checkSnapshot("time0_05");
        applyStimulus(ACT_TICK, 0, 0, 0, 0);
        applyStimulus(ACT_TICK, 0, 0, 0, 1);
        checkSnapshot("dieHoldDone");
        applyStimulus(ACT_TICK, 0, 1, 0, 0);
        checkSnapshot("time1_00");
        applyStimulus(ACT_TICK, 0, 0, 0, 0);
        applyStimulus(ACT_TICK, 0, 0, 0, 1);
        checkSnapshot("preReset");

        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        modelReset();
        checkOutput("asyncReset.state", 32'(bus.state), S_IDLE);
        checkOutput("asyncReset.pause", 32'(bus.timer_pause), 1);
        checkOutput("asyncReset.lives", 32'(bus.lives), LIVES);
        checkOutput("asyncReset.level", 32'(bus.level), 0);
        checkOutput("asyncReset.over", 32'(bus.game_over), 0);
        @(negedge clk) reset = 1'b0;
        waitCycles(2);
        checkSnapshot("afterReset");

        applyStimulus(ACT_START, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(ACT_HIT, 0, 0, 0, 0);
            checkSnapshot($sformatf("hit%0d", i));
            applyStimulus(ACT_TICK, 0, 0, 0, 0);
            applyStimulus(ACT_TICK, 0, 0, 0, 1);
            checkSnapshot($sformatf("hitHold%0d", i));
        end
        @(negedge clk) bus.frog_hit = 1'b1;
        @(negedge clk) bus.frog_hit = 1'b0;
        checkOutput("lastHit.dieState", 32'(bus.state), S_DIE);
        checkOutput("lastHit.lives", 32'(bus.lives), 0);
        @(negedge clk);
        checkOutput("lastHit.overState", 32'(bus.state), S_OVER);
        modelEvent(ACT_HIT, 0);
        waitCycles(2);
        checkSnapshot("gameLost");
        applyStimulus(ACT_START, 0, 0, 0, 0);
        checkSnapshot("restart");

        applyStimulus(ACT_START, 0, 0, 0, 0);
        applyStimulus(ACT_HOME, 0, 0, 0, 0);
        applyStimulus(ACT_TICK, 0, 0, 0, 0);
        applyStimulus(ACT_TICK, 0, 0, 0, 1);
        checkSnapshot("level1Run");
        @(negedge clk) begin bus.frog_home = 1'b1; bus.frog_hit = 1'b1; end
        @(negedge clk) begin bus.frog_home = 1'b0; bus.frog_hit = 1'b0; end
        checkOutput("finalWin.winState", 32'(bus.state), S_WIN);
        @(negedge clk);
        checkOutput("finalWin.overState", 32'(bus.state), S_OVER);
        modelEvent(ACT_BOTH, 0);
        waitCycles(2);
        checkSnapshot("gameWon");
        applyStimulus(ACT_START, 0, 0, 0, 0);
        checkSnapshot("idleAgain");

        for (int i = 0; i < 80; i++) begin
            act = int'($urandom_range(8));
            if (act > ACT_TICK) act = ACT_TICK;
            m1  = ($urandom_range(3) == 0) ? 4'd1 : 4'd0;
            s10 = ($urandom_range(2) == 0) ? 4'($urandom_range(5)) : 4'd0;
            s1  = 4'($urandom_range(9));
            applyStimulus(act, 4'd0, m1, s10, s1);
            checkSnapshot($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
